// File: rtl/main_driver_pkg.sv
// Shared types and widths for the main_driver command/response sequencer.
package main_driver_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 8;
  localparam int ON_W     = 2;
  localparam int S_W      = 3;
  localparam int REGIME_W = 2;
  localparam int CNT_W    = 8;

  localparam int DEF_START_WAIT = 15;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACT,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/main_driver_job_counter.sv
// Saturating up-counter shared by the start-wait and run-length limits.
module job_counter
  import main_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  // clr together with inc restarts the count at one
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/main_driver.sv
// Issues one job at a time to the main unit, tracks its start/active handshake
// and returns the captured results with a cycle count and timeout flag.
module main_driver
  import main_driver_pkg::*;
#(
  parameter int START_WAIT = DEF_START_WAIT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x,
  input  logic [ON_W-1:0]     cmd_on,
  output logic [X_W-1:0]      x,
  output logic [ON_W-1:0]     on,
  output logic                start,
  input  logic [Y_W-1:0]      y,
  input  logic [S_W-1:0]      s,
  input  logic                b,
  input  logic [REGIME_W-1:0] regime,
  input  logic                active,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [Y_W-1:0]      rsp_y,
  output logic [S_W-1:0]      rsp_s,
  output logic                rsp_b,
  output logic [REGIME_W-1:0] rsp_regime,
  output logic [CNT_W-1:0]    rsp_cycles,
  output logic                rsp_timeout,
  output logic                busy
);

  // state    | meaning
  // IDLE     | ready for a command
  // LAUNCH   | start pulse, counter cleared
  // WAIT_ACT | waiting for the unit to raise active
  // RUN      | counting active-high cycles
  // DONE     | response held until taken

  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_WAIT);
  localparam logic [CNT_W-1:0] RUN_LIM   = CNT_W'(TIMEOUT);

  state_t           state, state_next;
  logic             latch_cmd, capture, cap_timeout;
  logic             cnt_clr, cnt_inc, at_limit;
  logic [CNT_W-1:0] count, cap_cycles, limit;

  assign limit = (state == RUN) ? RUN_LIM : START_LIM;

  job_counter u_job_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .limit    (limit),
    .count    (count),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // active is checked before the limit so a coincident rise/fall wins
  always_comb begin
    state_next  = state;
    latch_cmd   = 1'b0;
    capture     = 1'b0;
    cap_timeout = 1'b0;
    cap_cycles  = '0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          latch_cmd  = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_clr    = 1'b1;
        state_next = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (active) begin
          cnt_clr    = 1'b1;
          cnt_inc    = 1'b1;
          state_next = RUN;
        end else if (at_limit) begin
          capture     = 1'b1;
          cap_timeout = 1'b1;
          state_next  = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RUN: begin
        if (!active) begin
          capture    = 1'b1;
          cap_cycles = count;
          state_next = DONE;
        end else if (at_limit) begin
          capture     = 1'b1;
          cap_timeout = 1'b1;
          cap_cycles  = RUN_LIM;
          state_next  = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x  <= '0;
      on <= '0;
    end else if (latch_cmd) begin
      x  <= cmd_x;
      on <= cmd_on;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_y       <= '0;
      rsp_s       <= '0;
      rsp_b       <= 1'b0;
      rsp_regime  <= '0;
      rsp_cycles  <= '0;
      rsp_timeout <= 1'b0;
    end else if (capture) begin
      rsp_y       <= y;
      rsp_s       <= s;
      rsp_b       <= b;
      rsp_regime  <= regime;
      rsp_cycles  <= cap_cycles;
      rsp_timeout <= cap_timeout;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign start     = (state == LAUNCH);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
